// File: rtl/ycbcr2rgb.sv
// ycbcr2rgb: three-stage pipelined full-range BT.601 YCbCr -> RGB converter.
// Stage 1 centres chroma and scales luma, stage 2 forms the four products,
// stage 3 sums, rounds, floors and saturates. valid/sof travel alongside.
module ycbcr2rgb #(
    parameter int FRAC = 14  // fractional coefficient bits, 10..16
) (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic       iEn,
    input  logic       iValid,
    input  logic       iSof,
    input  logic [7:0] iY,
    input  logic [7:0] iCb,
    input  logic [7:0] iCr,
    output logic       oValid,
    output logic       oSof,
    output logic [7:0] oR,
    output logic [7:0] oG,
    output logic [7:0] oB
);

    // Accumulator width leaves headroom well beyond the worst-case sum.
    localparam int ACC = FRAC + 12;

    // Coefficients are round(c * 2^FRAC), evaluated in integer arithmetic.
    localparam logic signed [ACC-1:0] KR   = ACC'(((64'd1402   << FRAC) + 64'd500)    / 64'd1000);
    localparam logic signed [ACC-1:0] KGB  = ACC'(((64'd344136 << FRAC) + 64'd500000) / 64'd1000000);
    localparam logic signed [ACC-1:0] KGR  = ACC'(((64'd714136 << FRAC) + 64'd500000) / 64'd1000000);
    localparam logic signed [ACC-1:0] KB   = ACC'(((64'd1772   << FRAC) + 64'd500)    / 64'd1000);
    localparam logic signed [ACC-1:0] HALF = ACC'(64'd1 << (FRAC - 1));
    localparam logic signed [ACC-1:0] MAX8 = ACC'(255);

    // Stage 1
    logic                  r_v1;
    logic                  r_sof1;
    logic signed [ACC-1:0] r_ys1;
    logic signed [8:0]     r_d;
    logic signed [8:0]     r_e;
    // Stage 2
    logic                  r_v2;
    logic                  r_sof2;
    logic signed [ACC-1:0] r_ys2;
    logic signed [ACC-1:0] r_pr;
    logic signed [ACC-1:0] r_pgb;
    logic signed [ACC-1:0] r_pgr;
    logic signed [ACC-1:0] r_pb;
    // Stage 3
    logic                  r_v3;
    logic                  r_sof3;
    logic [7:0]            r_r;
    logic [7:0]            r_g;
    logic [7:0]            r_b;

    logic signed [ACC-1:0] w_d;
    logic signed [ACC-1:0] w_e;
    logic signed [ACC-1:0] w_sr;
    logic signed [ACC-1:0] w_sg;
    logic signed [ACC-1:0] w_sb;
    logic [7:0]            w_r;
    logic [7:0]            w_g;
    logic [7:0]            w_b;

    // Floor-shift a rounded sum back to integer and clamp into 0..255.
    function automatic logic [7:0] sat8(input logic signed [ACC-1:0] sum);
        logic signed [ACC-1:0] q;
        q = sum >>> FRAC;
        if (q[ACC-1])
            return 8'd0;
        else if (q > MAX8)
            return 8'hFF;
        else
            return q[7:0];
    endfunction

    assign w_d = {{(ACC-9){r_d[8]}}, r_d};
    assign w_e = {{(ACC-9){r_e[8]}}, r_e};

    // Stage-3 sums with rounding offset, then saturation.
    always_comb begin
        w_sr = r_ys2 + r_pr + HALF;
        w_sg = r_ys2 - r_pgb - r_pgr + HALF;
        w_sb = r_ys2 + r_pb + HALF;
        w_r  = sat8(w_sr);
        w_g  = sat8(w_sg);
        w_b  = sat8(w_sb);
    end

    // Pipeline registers; iEn=0 freezes every stage including valid/sof.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_v1   <= 1'b0;
            r_sof1 <= 1'b0;
            r_ys1  <= '0;
            r_d    <= '0;
            r_e    <= '0;
            r_v2   <= 1'b0;
            r_sof2 <= 1'b0;
            r_ys2  <= '0;
            r_pr   <= '0;
            r_pgb  <= '0;
            r_pgr  <= '0;
            r_pb   <= '0;
            r_v3   <= 1'b0;
            r_sof3 <= 1'b0;
            r_r    <= '0;
            r_g    <= '0;
            r_b    <= '0;
        end else if (iEn) begin
            r_v1   <= iValid;
            r_sof1 <= iSof & iValid;
            r_ys1  <= {{(ACC-8-FRAC){1'b0}}, iY, {FRAC{1'b0}}};
            r_d    <= 9'({1'b0, iCb}) - 9'd128;
            r_e    <= 9'({1'b0, iCr}) - 9'd128;

            r_v2   <= r_v1;
            r_sof2 <= r_sof1;
            r_ys2  <= r_ys1;
            r_pr   <= KR  * w_e;
            r_pgb  <= KGB * w_d;
            r_pgr  <= KGR * w_e;
            r_pb   <= KB  * w_d;

            r_v3   <= r_v2;
            r_sof3 <= r_sof2;
            r_r    <= w_r;
            r_g    <= w_g;
            r_b    <= w_b;
        end
    end

    assign oValid = r_v3;
    assign oSof   = r_sof3;
    assign oR     = r_r;
    assign oG     = r_g;
    assign oB     = r_b;

endmodule
